// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: widths, instruction field
// positions, NOP encoding and the fetch-stage state type.
package mips_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned INSTR_W_DEF = 32;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned JIDX_MSB = 25;
    localparam int unsigned JIDX_LSB = 0;
    localparam int unsigned JIDX_W   = JIDX_MSB - JIDX_LSB + 1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FULL  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: valid-qualified word read.
interface instr_fetch_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC arithmetic: sequential increment and redirect target selection.
module next_pc_sel
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_if_pc_plus4,
    input  logic              i_jump,
    input  logic [JIDX_W-1:0] i_jump_index,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic [ADDR_W-1:0] o_redirect_target
);
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_branch_target;
    logic              w_unused_bits;

    // Only the region bits of the held PC+4 and the word bits of the branch
    // target take part in target formation.
    assign w_unused_bits = ^{i_if_pc_plus4[JIDX_W+1:0], i_branch_target[1:0]};

    // Increment wraps modulo 2^ADDR_W; jump beats branch when both fire.
    always_comb begin
        o_pc_plus4        = i_pc + ADDR_W'(4);
        w_jump_target     = {i_if_pc_plus4[ADDR_W-1:JIDX_W+2], i_jump_index, 2'b00};
        w_branch_target   = {i_branch_target[ADDR_W-1:2], 2'b00};
        o_redirect_target = i_jump ? w_jump_target : w_branch_target;
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and holds
// the returned word in the IF/ID register until the decoder consumes it.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_if.master       imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                jump,
    input  logic [JIDX_W-1:0]   jump_index,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc_plus4,
    output logic [5:0]          opcode
);
    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc_plus4;

    logic               w_redirect;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic [ADDR_W-1:0]  w_redirect_target;

    assign w_redirect = jump | branch_taken;

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .i_pc              (r_pc),
        .i_if_pc_plus4     (r_if_pc_plus4),
        .i_jump            (jump),
        .i_jump_index      (jump_index),
        .i_branch_target   (branch_target),
        .o_pc_plus4        (w_pc_plus4),
        .o_redirect_target (w_redirect_target)
    );

    // Request is a decode of the state register, forced low while in reset
    // because the reset state is already FETCH.
    assign imem.imem_req  = rst_n & (r_state == FETCH);
    assign imem.imem_addr = r_pc;

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign opcode      = r_if_instr[OPC_MSB:OPC_LSB];

    // Fetch FSM: a redirect flushes and restarts from any state, beating both
    // stall and a same-cycle memory response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= INSTR_W'(NOP_INSTR);
            r_if_pc_plus4 <= '0;
        end else if (w_redirect) begin
            r_pc       <= w_redirect_target;
            r_if_valid <= 1'b0;
            r_state    <= FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem.imem_valid) begin
                        r_if_instr    <= imem.imem_rdata;
                        r_if_pc_plus4 <= w_pc_plus4;
                        r_pc          <= w_pc_plus4;
                        r_if_valid    <= 1'b1;
                        r_state       <= FULL;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        r_if_valid <= 1'b0;
                        r_state    <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the main control decoder.
- Holds the PC and issues word reads to instruction memory over a valid-qualified read handshake.
- Latches the returned instruction into an IF/ID holding register and presents its opcode field to the decoder.
- Applies branch/jump redirects issued by the downstream stages and honours a downstream stall.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  word-aligned read address (bits [1:0] always 0).
- imem_rdata  in  INSTR_W  read data; valid only when imem_valid=1.
- imem_valid  in  1  imem_rdata corresponds to the imem_addr driven in this same cycle.
- stall  in  1  downstream cannot accept the held instruction this cycle.
- branch_taken  in  1  redirect to branch_target (single-cycle pulse).
- branch_target  in  ADDR_W  branch destination; bits [1:0] ignored.
- jump  in  1  redirect to jump target (single-cycle pulse).
- jump_index  in  26  instr[25:0] of the jump instruction.
- if_valid  out  1  if_instr holds a live instruction.
- if_instr  out  INSTR_W  held instruction.
- if_pc_plus4  out  ADDR_W  PC+4 of the held instruction.
- opcode  out  6  if_instr[31:26], combinational, feeds the control decoder.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - if_valid=0, if_instr=0 (NOP, so opcode=000000), if_pc_plus4=0.
  - imem_req goes low while rst_n=0.
- States: FETCH, FULL.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Address is held stable until imem_valid=1 or a redirect occurs.
  - On imem_valid=1 (no redirect) at the clock edge: if_instr<=imem_rdata, if_pc_plus4<=pc+4, pc<=pc+4, if_valid<=1, go to FULL.
  - Best-case latency: instruction visible on if_instr one cycle after imem_valid.
- FULL:
  - imem_req=0, if_valid=1, all IF outputs held.
  - stall=1: stay in FULL and hold outputs.
  - stall=0: instruction is consumed this edge; if_valid<=0, go to FETCH.
  - Peak throughput is therefore one instruction per 2 cycles with zero-wait memory.
- Redirect:
  - redirect = jump | branch_taken. Jump has priority when both are asserted.
  - Jump target = {if_pc_plus4[31:28], jump_index, 2'b00}.
  - Branch target = {branch_target[31:2], 2'b00}.
  - Redirect in any state: pc<=target, if_valid<=0, state<=FETCH.
  - Redirect beats stall.
  - Redirect in FETCH in the same cycle as imem_valid=1: the returned data is discarded, nothing is latched, and the next cycle requests the target.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- imem_valid while imem_req=0 is ignored.
- Reset asserted mid-request abandons the request; after release, fetch restarts at RESET_PC.
- if_instr and if_pc_plus4 change only on a FETCH capture; flush clears only if_valid.
- Decoder obligation: a held instruction with if_valid=0 must be treated as a NOP.

Decomposition:
- Shared package (mips_pkg):
  - ADDR_W and INSTR_W defaults.
  - Opcode field positions [31:26] and jump-index field positions [25:0].
  - NOP encoding 32'h0.
  - fetch_state_t enum {FETCH, FULL}.
- Optional sub-module next_pc_sel: combinational selection of pc+4 / branch / jump target. Everything else stays in instr_fetch.

Test Plan:
- Reset release, zero-wait memory returning 32'h8C01_0004 at addr 0 -> imem_addr=0 while rst_n=0 and imem_req=0 during reset; one cycle after imem_valid: if_valid=1, if_instr=32'h8C01_0004, opcode=6'b100011, if_pc_plus4=4; next fetch is at addr 4.
- Memory with 3 wait cycles -> imem_addr=0 stays stable for 4 cycles; if_valid rises exactly one cycle after imem_valid.
- stall=1 for 5 cycles in FULL -> outputs frozen, imem_req=0; after stall drops, next request is at if_pc_plus4.
- Held jump with if_pc_plus4=32'h4000_0010, jump_index=26'h0000100 -> next imem_addr=32'h4000_0400 and if_valid=0; assert jump and branch_taken together -> jump target wins.
- branch_taken with target 32'h0000_0043 arriving in FETCH in the same cycle as imem_valid -> data not latched, if_valid stays 0, next imem_addr=32'h0000_0040.
- PC at 32'hFFFF_FFFC fetched -> if_pc_plus4=0 and next imem_addr=0; async reset mid-FETCH -> outputs clear immediately and fetch restarts at RESET_PC.
